cart_bank_mapper: RTL and testbench

//  Parametrised cartridge bank mapper and ROM read bridge. Sits between the console core's ROM

---
 rtl/cart_bank_mapper.sv | 133 +++++++++++++
 tb/tb_cart_bank_mapper.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cart_bank_mapper.sv
// cart_bank_mapper: cartridge bank mapper and ROM read bridge between toggle handshakes.
// Define CART_BANK_MAPPER_WRAP_EN to AND translated addresses with rom_mask (ROM mirroring).
module cart_bank_mapper #(
  parameter int unsigned SLOTS       = 8,
  parameter int unsigned SLOT_AW     = 19,
  parameter int unsigned BANK_W      = 6,
  parameter int unsigned FIXED_SLOT0 = 1,
  localparam int unsigned SW         = $clog2(SLOTS),
  localparam int unsigned PAW        = BANK_W + SLOT_AW
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  map_we,
  input  logic [SW-1:0]         map_a,
  input  logic [BANK_W-1:0]     map_d,
  input  logic [SLOT_AW+SW-1:1] cpu_addr,
  input  logic                  cpu_req,
  output logic                  cpu_ack,
  output logic [15:0]           cpu_dout,
  output logic [PAW-1:1]        mem_addr,
  output logic                  mem_req,
  input  logic                  mem_ack,
  input  logic [15:0]           mem_din,
  input  logic [PAW-1:1]        rom_mask,
  output logic                  use_map,
  output logic                  busy
);

  typedef enum logic [1:0] {StIdle, StXlate, StWait, StDrain} state_e;

  state_e                  state_q, state_d;
  logic [SLOT_AW+SW-1:1]   addr_q, addr_d;
  logic [BANK_W-1:0]       bank_q [SLOTS];
  logic [BANK_W-1:0]       bank_d [SLOTS];
  logic                    use_map_q, use_map_d;
  logic                    cpu_ack_q, cpu_ack_d;
  logic [15:0]             cpu_dout_q, cpu_dout_d;
  logic [PAW-1:1]          mem_addr_q, mem_addr_d;
  logic                    mem_req_q, mem_req_d;

  logic [SW-1:0]           slot;
  logic [PAW-1:1]          phys_mapped;
  logic [PAW-1:1]          phys_raw;
  logic [PAW-1:1]          phys;

  assign slot        = addr_q[SLOT_AW+SW-1:SLOT_AW];
  assign phys_mapped = {bank_q[slot], addr_q[SLOT_AW-1:1]};
  assign phys_raw    = use_map_q ? phys_mapped : (PAW-1)'(addr_q);

`ifdef CART_BANK_MAPPER_WRAP_EN
  assign phys = phys_raw & rom_mask;
`else
  logic unused_rom_mask;
  assign unused_rom_mask = ^rom_mask;
  assign phys            = phys_raw;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    bank_d     = bank_q;
    use_map_d  = use_map_q;
    cpu_ack_d  = cpu_ack_q;
    cpu_dout_d = cpu_dout_q;
    mem_addr_d = mem_addr_q;
    mem_req_d  = mem_req_q;

    // Bank writes land on the next edge, so an XLATE in progress still sees the old value.
    if (map_we && !((FIXED_SLOT0 != 0) && (map_a == '0))) begin
      bank_d[map_a] = map_d;
      use_map_d     = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (cpu_req != cpu_ack_q) begin
          addr_d  = cpu_addr;
          state_d = StXlate;
        end
      end
      StXlate: begin
        mem_addr_d = phys;
        mem_req_d  = ~mem_req_q;
        state_d    = StWait;
      end
      StWait: begin
        if (mem_ack == mem_req_q) begin
          cpu_dout_d = mem_din;
          cpu_ack_d  = ~cpu_ack_q;
          state_d    = StIdle;
        end
      end
      StDrain: begin
        if (mem_ack == mem_req_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // mem_req is left alone so an outstanding DDR access can finish and be drained.
    if (reset) begin
      cpu_ack_d  = cpu_req;
      cpu_dout_d = '0;
      mem_addr_d = '0;
      use_map_d  = 1'b0;
      addr_d     = '0;
      for (int unsigned i = 0; i < SLOTS; i++) begin
        bank_d[i] = BANK_W'(i);
      end
      state_d = (mem_req_q != mem_ack) ? StDrain : StIdle;
    end
  end

  always_ff @(posedge clk_sys) begin
    state_q    <= state_d;
    addr_q     <= addr_d;
    bank_q     <= bank_d;
    use_map_q  <= use_map_d;
    cpu_ack_q  <= cpu_ack_d;
    cpu_dout_q <= cpu_dout_d;
    mem_addr_q <= mem_addr_d;
    mem_req_q  <= mem_req_d;
  end

  assign cpu_ack  = cpu_ack_q;
  assign cpu_dout = cpu_dout_q;
  assign mem_addr = mem_addr_q;
  assign mem_req  = mem_req_q;
  assign use_map  = use_map_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_cart_bank_mapper.sv
// Bench for cart_bank_mapper: directed cases plus randomized reads checked by a scoreboard.
module tb_cart_bank_mapper;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        map_we = 1'b0;
  logic [2:0]  map_a = '0;
  logic [5:0]  map_d = '0;
  logic [21:1] cpu_addr = '0;
  logic        cpu_req = 1'b0;
  logic        cpu_ack;
  logic [15:0] cpu_dout;
  logic [24:1] mem_addr;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_din = '0;
  logic [24:1] rom_mask = '1;
  logic        use_map;
  logic        busy;

  cart_bank_mapper dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .map_we   (map_we),
    .map_a    (map_a),
    .map_d    (map_d),
    .cpu_addr (cpu_addr),
    .cpu_req  (cpu_req),
    .cpu_ack  (cpu_ack),
    .cpu_dout (cpu_dout),
    .mem_addr (mem_addr),
    .mem_req  (mem_req),
    .mem_ack  (mem_ack),
    .mem_din  (mem_din),
    .rom_mask (rom_mask),
    .use_map  (use_map),
    .busy     (busy)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_pass   = 0;

  logic [23:0] exp_addr[$];
  logic [15:0] exp_dout[$];

  // Reference model state: bank contents and mapping enable as the spec describes them.
  int unsigned ref_bank[8];
  bit          ref_use_map;

  int          force_lat = 0;
  bit          force_data_en = 1'b0;
  logic [15:0] force_data = '0;
  bit          ddr_discard = 1'b0;
  bit          ddr_busy = 1'b0;
  int          ddr_cnt = 0;
  logic        mon_ack = 1'b0;
  logic        mon_req = 1'b0;
  bit          drained;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  function automatic logic [23:0] model_phys(input logic [20:0] a);
    int unsigned word = a;
    int unsigned p;
    if (ref_use_map) p = (ref_bank[word / 32'h40000] * 32'h40000) + (word % 32'h40000);
    else p = word;
`ifdef CART_BANK_MAPPER_WRAP_EN
    p = p & 32'(rom_mask);
`endif
    return p[23:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) ref_bank[i] = i;
    ref_use_map = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk_sys);
    #1;
    map_we = 1'b0;
  endtask

  task automatic set_write(input int unsigned a, input int unsigned d);
    map_we = 1'b1;
    map_a  = 3'(a);
    map_d  = 6'(d);
    if (a != 0) begin
      ref_bank[a] = d % 64;
      ref_use_map = 1'b1;
    end
  endtask

  task automatic start_read(input logic [20:0] a);
    cpu_addr = a;
    cpu_req  = ~cpu_req;
    exp_addr.push_back(model_phys(a));
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (cpu_ack == cpu_req) break;
    end
    chk({name, "_ack"}, cpu_ack, cpu_req);
  endtask

  task automatic rd(input string name, input logic [20:0] a, input logic [23:0] exp,
                    input bit xw, input int unsigned xa, input int unsigned xd);
    start_read(a);
    tick();
    chk({name, "_busy"}, busy, 1'b1);
    if (xw) set_write(xa, xd);
    tick();
    chk({name, "_addr"}, mem_addr, exp);
    wait_done(name);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    model_reset();
    repeat (cycles) tick();
    reset = 1'b0;
  endtask

  // DDR model: acknowledges each toggle after a random or forced delay.
  initial begin
    forever begin
      @(negedge clk_sys);
      #1;
      if (mem_req != mem_ack) begin
        if (!ddr_busy) begin
          ddr_busy = 1'b1;
          ddr_cnt  = (force_lat > 0) ? force_lat : int'($urandom_range(0, 3));
        end
        if (ddr_cnt == 0) begin
          mem_din  = force_data_en ? force_data : 16'($urandom);
          mem_ack  = mem_req;
          ddr_busy = 1'b0;
          if (ddr_discard) ddr_discard = 1'b0;
          else exp_dout.push_back(mem_din);
        end else begin
          ddr_cnt--;
        end
      end
    end
  end

  // Address monitor: every DDR request toggle is checked against the expected address.
  initial begin
    forever begin
      @(negedge clk_sys);
      if (mem_req != mon_req) begin
        mon_req = mem_req;
        if (exp_addr.size() == 0) begin
          n_checks++;
          $display("FAIL mem_addr_unexpected: got 0x%0h expected no request", mem_addr);
        end else begin
          chk("mem_addr", mem_addr, exp_addr.pop_front());
        end
      end
    end
  end

  // Data monitor: every CPU ack toggle outside reset must carry the next expected word.
  initial begin
    forever begin
      @(negedge clk_sys);
      if (reset) begin
        mon_ack = cpu_ack;
      end else if (cpu_ack != mon_ack) begin
        mon_ack = cpu_ack;
        if (exp_dout.size() == 0) begin
          n_checks++;
          $display("FAIL cpu_dout_unexpected: got 0x%0h expected no ack", cpu_dout);
        end else begin
          chk("cpu_dout", cpu_dout, exp_dout.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [20:0] ra;
    int unsigned pre;
    model_reset();
    do_reset(3);
    chk("rst_ack", cpu_ack, cpu_req);
    chk("rst_dout", cpu_dout, 16'h0);
    chk("rst_addr", mem_addr, 24'h0);
    chk("rst_use_map", use_map, 1'b0);
    chk("rst_busy", busy, 1'b0);

    // Basic unmapped read with fixed data.
    force_data_en = 1'b1;
    force_data    = 16'hBEEF;
    rd("t1", 21'h12345, 24'h012345, 1'b0, 0, 0);
    chk("t1_dout", cpu_dout, 16'hBEEF);
    force_data_en = 1'b0;

    // Slot 0 write is ignored.
    set_write(0, 5);
    tick();
    tick();
    chk("t3_use_map", use_map, 1'b0);
    rd("t3", 21'h01234, 24'h001234, 1'b0, 0, 0);

    // Mapped read through slot 3.
    set_write(3, 6'h2A);
    tick();
    chk("t2_use_map", use_map, 1'b1);
    rd("t2", 21'h0C0010, 24'hA80010, 1'b0, 0, 0);

    // Write during XLATE affects only the following request.
    rd("t5a", 21'h0C0020, 24'hA80020, 1'b1, 3, 6'h15);
    rd("t5b", 21'h0C0020, 24'h540020, 1'b0, 0, 0);

    // Reset during WAIT drains the outstanding DDR access.
    force_lat     = 10;
    force_data_en = 1'b1;
    force_data    = 16'hDEAD;
    start_read(21'h00222);
    tick();
    tick();
    chk("t4_busy_wait", busy, 1'b1);
    reset       = 1'b1;
    ddr_discard = 1'b1;
    model_reset();
    tick();
    reset   = 1'b0;
    drained = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!busy) begin
        drained = 1'b1;
        break;
      end
      chk("t4_dout_drain", cpu_dout, 16'h0);
    end
    chk("t4_drained", drained, 1'b1);
    chk("t4_ddr_acked_first", ddr_discard, 1'b0);
    chk("t4_dout", cpu_dout, 16'h0);
    chk("t4_ack", cpu_ack, cpu_req);
    chk("t4_use_map", use_map, 1'b0);
    force_lat     = 0;
    force_data_en = 1'b0;
    rd("t4_next", 21'h00100, 24'h000100, 1'b0, 0, 0);

    // Unmapped read against a 512 KiB ROM mask.
    do_reset(2);
    rom_mask = 24'h03FFFF;
`ifdef CART_BANK_MAPPER_WRAP_EN
    rd("t6", 21'h050000, 24'h010000, 1'b0, 0, 0);
`else
    rd("t6", 21'h050000, 24'h050000, 1'b0, 0, 0);
`endif

    // Randomized reads with bank writes around the request.
    for (int n = 0; n < 80; n++) begin
      repeat ($urandom_range(0, 2)) begin
        if ($urandom_range(0, 1) == 1) set_write($urandom_range(0, 7), $urandom_range(0, 63));
        tick();
      end
      rom_mask = 24'((32'd1 << $urandom_range(17, 24)) - 1);
      ra  = 21'($urandom);
      pre = $urandom_range(0, 3);
      if (pre == 0) set_write($urandom_range(0, 7), $urandom_range(0, 63));
      start_read(ra);
      tick();
      if (pre == 1) set_write($urandom_range(0, 7), $urandom_range(0, 63));
      wait_done("rand");
    end
    tick();
    chk("rand_use_map", use_map, ref_use_map);

    repeat (5) tick();
    chk("addr_queue_empty", exp_addr.size(), 0);
    chk("dout_queue_empty", exp_dout.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
